alu_cmd_sequencer: RTL and testbench

Parametrised command sequencer between the UART and the ALU, successor to the single-byte operand collector. It parses framed commands from received UART bytes: header, opcode, multi-byte operands A and B. It drives the ALU, captures the result and returns it as a multi-byte response with a full transmit handshake. Unlike its predecessor, it adds a header byte, operands wider than one UART byte, a receive timeout and an error response.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/seq_timeout.sv | 29 ++
 rtl/alu_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the UART-to-ALU command sequencer.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_OP,
    GET_A,
    GET_B,
    EXEC,
    TX_START,
    TX_WAIT,
    ERR_START,
    ERR_WAIT
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT   = 8'hA5;
  localparam logic [7:0] ERR_CODE_DEFAULT = 8'hEE;

  function automatic int bytes_of(input int nb_operand, input int nb_data);
    return nb_operand / nb_data;
  endfunction

  // Width needed to count 0..n-1, never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_timeout.sv
// Idle counter for frame reception: expires after TIMEOUT_CYCLES enabled clocks without a clear.
module seq_timeout
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Parses HEADER/OP/A/B frames from the UART, drives the ALU and returns the
// result LSB-first through a start/done transmit handshake.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int                  NB_DATA        = 8,
  parameter int                  NB_OPERAND     = 16,
  parameter int                  NB_OP          = 6,
  parameter logic [NB_DATA-1:0]  HEADER         = NB_DATA'(HEADER_DEFAULT),
  parameter logic [NB_DATA-1:0]  ERR_CODE       = NB_DATA'(ERR_CODE_DEFAULT),
  parameter int                  TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_DATA-1:0]    i_rx_data,
  input  logic                  i_rx_done_tick,
  input  logic                  i_tx_done_tick,
  input  logic [NB_OPERAND-1:0] i_result,
  output logic [NB_OPERAND-1:0] o_data_a,
  output logic [NB_OPERAND-1:0] o_data_b,
  output logic [NB_OP-1:0]      o_operation,
  output logic [NB_DATA-1:0]    o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_frame_error
);

  localparam int            BYTES    = bytes_of(NB_OPERAND, NB_DATA);
  localparam int            IW       = cnt_width(BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  generate
    if ((NB_OPERAND % NB_DATA) != 0 || NB_OP > NB_DATA || NB_OPERAND < NB_DATA
        || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("alu_cmd_sequencer: illegal parameter combination");
    end
  endgenerate

  state_t                         state, state_n;
  logic [IW-1:0]                  idx, idx_n;
  logic [BYTES-1:0][NB_DATA-1:0]  a_q, a_n, b_q, b_n, res_q, res_n, res_in;
  logic [NB_OP-1:0]               op_q, op_n;
  logic [NB_DATA-1:0]             txd_q, txd_n;
  logic                           ferr_q, ferr_n;
  logic                           tmo_clear, tmo_enable, tmo_expired;

  assign res_in     = i_result;
  assign tmo_enable = (state == GET_OP) || (state == GET_A) || (state == GET_B);
  // Holding the counter clear outside reception also covers the entry into GET_OP.
  assign tmo_clear  = i_rx_done_tick || !tmo_enable;

  seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_clock),
    .rst    (i_reset),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    res_n   = res_q;
    txd_n   = txd_q;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_done_tick && (i_rx_data == HEADER)) state_n = GET_OP;
      end
      GET_OP: begin
        if (i_rx_done_tick) begin
          if ((i_rx_data >> NB_OP) != '0) begin
            ferr_n  = 1'b1;
            txd_n   = ERR_CODE;
            state_n = ERR_START;
          end else begin
            op_n    = i_rx_data[NB_OP-1:0];
            idx_n   = '0;
            state_n = GET_A;
          end
        end else if (tmo_expired) begin
          ferr_n  = 1'b1;
          state_n = IDLE;
        end
      end
      GET_A, GET_B: begin
        if (i_rx_done_tick) begin
          if (state == GET_A) a_n[idx] = i_rx_data;
          else                b_n[idx] = i_rx_data;
          if (idx == LAST_IDX) begin
            idx_n   = '0;
            state_n = (state == GET_A) ? GET_B : EXEC;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else if (tmo_expired) begin
          ferr_n  = 1'b1;
          state_n = IDLE;
        end
      end
      EXEC: begin
        // Byte 0 is loaded straight from the ALU so it is valid in TX_START.
        res_n   = res_in;
        txd_n   = res_in[0];
        idx_n   = '0;
        state_n = TX_START;
      end
      TX_START:  state_n = TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done_tick) begin
          if (idx == LAST_IDX) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + IW'(1);
            txd_n   = res_q[idx_n];
            state_n = TX_START;
          end
        end
      end
      ERR_START: state_n = ERR_WAIT;
      ERR_WAIT: begin
        if (i_tx_done_tick) state_n = IDLE;
      end
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      txd_q  <= '0;
      ferr_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      a_q    <= a_n;
      b_q    <= b_n;
      op_q   <= op_n;
      res_q  <= res_n;
      txd_q  <= txd_n;
      ferr_q <= ferr_n;
    end
  end

  assign o_data_a      = a_q;
  assign o_data_b      = b_q;
  assign o_operation   = op_q;
  assign o_tx_data     = txd_q;
  assign o_tx_start    = (state == TX_START) || (state == ERR_START);
  assign o_busy        = (state != IDLE);
  assign o_frame_error = ferr_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a frame-level response model and a UART TX responder.
module tb_alu_cmd_sequencer;

  localparam int NB_DATA    = 8;
  localparam int NB_OPERAND = 16;
  localparam int NB_OP      = 6;
  localparam int BYTES      = NB_OPERAND / NB_DATA;
  localparam int TMO        = 50;
  localparam int TX_DELAY   = 8;

  typedef logic [7:0] bq_t[$];

  logic                  clk = 1'b0;
  logic                  i_reset = 1'b1;
  logic [NB_DATA-1:0]    rx_data = '0;
  logic                  rx_tick = 1'b0;
  logic                  tx_done = 1'b0;
  logic [NB_OPERAND-1:0] result;
  logic [NB_OPERAND-1:0] data_a, data_b;
  logic [NB_OP-1:0]      operation;
  logic [NB_DATA-1:0]    tx_data;
  logic                  tx_start, busy, frame_error;

  int   checks = 0, errors = 0;
  int   cmp_checks = 0, cmp_errors = 0;
  bq_t  exp_q;
  bq_t  tx_log;
  int   rd_idx = 0;
  int   exp_err = 0, seen_err = 0;
  logic prev_start = 1'b0, prev_err = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign result = alu(operation, data_a, data_b);

  alu_cmd_sequencer #(
    .NB_DATA(NB_DATA), .NB_OPERAND(NB_OPERAND), .NB_OP(NB_OP),
    .HEADER(8'hA5), .ERR_CODE(8'hEE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_rx_data(rx_data), .i_rx_done_tick(rx_tick),
    .i_tx_done_tick(tx_done), .i_result(result), .o_data_a(data_a), .o_data_b(data_b),
    .o_operation(operation), .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
    .o_frame_error(frame_error)
  );

  // UART transmitter stand-in: records each requested byte, answers with a done tick later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && !i_reset) begin
        tx_log.push_back(tx_data);
        repeat (TX_DELAY) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Every transmit request and error pulse is checked against the model.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (tx_start) begin
        cmp_checks++;
        if (rd_idx >= exp_q.size()) begin
          cmp_errors++;
          $display("FAIL tx_byte: unexpected byte %h, no response byte expected", tx_data);
        end else begin
          if (tx_data !== exp_q[rd_idx]) begin
            cmp_errors++;
            $display("FAIL tx_byte[%0d]: got %h expected %h", rd_idx, tx_data, exp_q[rd_idx]);
          end
          rd_idx++;
        end
        if (prev_start) begin
          cmp_errors++;
          $display("FAIL tx_start_width: got 2+ cycles expected 1");
        end
      end
      if (frame_error) begin
        cmp_checks++;
        if (seen_err >= exp_err || prev_err) begin
          cmp_errors++;
          $display("FAIL frame_error: got pulse #%0d expected %0d pulses", seen_err + 1, exp_err);
        end
        seen_err++;
      end
    end
    prev_start = tx_start && !i_reset;
    prev_err   = frame_error && !i_reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: find headers, reject bad opcodes, compute complete frames.
  task automatic model_stream(input bq_t s);
    int          i;
    logic [7:0]  op;
    logic [15:0] a, b, r;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= s.size()) break;
      op = s[i+1];
      if (op[7:6] != 2'b00) begin
        exp_q.push_back(8'hEE);
        exp_err++;
        i += 2;
        continue;
      end
      if (i + 2 + 2 * BYTES > s.size()) break;
      for (int k = 0; k < BYTES; k++) begin
        a[8*k +: 8] = s[i+2+k];
        b[8*k +: 8] = s[i+2+BYTES+k];
      end
      r = alu(op[5:0], a, b);
      for (int k = 0; k < BYTES; k++) exp_q.push_back(r[8*k +: 8]);
      i += 2 + 2 * BYTES;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1 rx_data = b;
    rx_tick = 1'b1;
    @(posedge clk);
    #1 rx_tick = 1'b0;
  endtask

  task automatic send_bytes(input bq_t s);
    foreach (s[k]) rx_byte(s[k]);
  endtask

  task automatic frame(input bq_t s);
    model_stream(s);
    send_bytes(s);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (!busy && rd_idx == exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #2;
    check({name, "_idle"}, {31'd0, ok}, 32'd1);
    check({name, "_err_count"}, seen_err, exp_err);
  endtask

  task automatic wait_tx_start(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_tx_start_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_data_a"}, data_a, 0);
    check({name, "_data_b"}, data_b, 0);
    check({name, "_operation"}, operation, 0);
    check({name, "_tx_data"}, tx_data, 0);
    check({name, "_tx_start"}, tx_start, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_frame_error"}, frame_error, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    int  base;

    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    i_reset = 1'b0;

    // Happy path with literal latency and byte checks.
    base = tx_log.size();
    s = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00};
    frame(s);
    @(negedge clk);
    check("exec_no_start", tx_start, 0);
    check("exec_busy", busy, 1);
    @(negedge clk);
    check("first_start", tx_start, 1);
    check("first_byte", tx_data, 8'h35);
    wait_idle("happy");
    check("happy_log_len", tx_log.size() - base, 2);
    check("happy_byte0", tx_log[base], 8'h35);
    check("happy_byte1", tx_log[base+1], 8'h12);

    // Junk before the header.
    s = '{8'h00, 8'h7F, 8'hA5, 8'h22, 8'h10, 8'h00, 8'h01, 8'h00};
    frame(s);
    wait_idle("resync");

    // Bad opcode, then a good frame.
    s = '{8'hA5, 8'h40};
    frame(s);
    @(negedge clk);
    check("badop_error", frame_error, 1);
    check("badop_start", tx_start, 1);
    check("badop_byte", tx_data, 8'hEE);
    wait_idle("badop");
    base = tx_log.size();
    s = '{8'hA5, 8'h20, 8'h01, 8'h00, 8'h01, 8'h00};
    frame(s);
    wait_idle("after_badop");
    check("after_badop_byte0", tx_log[base], 8'h02);
    check("after_badop_byte1", tx_log[base+1], 8'h00);

    // Timeout: silence after the first A byte.
    base = tx_log.size();
    exp_err++;
    s = '{8'hA5, 8'h20, 8'h34};
    send_bytes(s);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    check("tmo_before_error", frame_error, 0);
    check("tmo_before_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("tmo_error", frame_error, 1);
    check("tmo_busy", busy, 0);
    wait_idle("timeout");
    check("tmo_no_tx", tx_log.size() - base, 0);

    // A tick in the expiry cycle is accepted.
    s = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00};
    model_stream(s);
    s = '{8'hA5, 8'h20, 8'h34};
    send_bytes(s);
    repeat (TMO - 3) @(posedge clk);
    s = '{8'h12, 8'h01, 8'h00};
    send_bytes(s);
    wait_idle("expiry_tick");

    // Bytes arriving during transmission are dropped.
    s = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00};
    frame(s);
    wait_tx_start("drop");
    rx_byte(8'hA5);
    rx_byte(8'h22);
    wait_idle("drop");
    check("drop_data_a", data_a, 16'h1234);
    check("drop_data_b", data_b, 16'h0001);
    check("drop_operation", operation, 6'h20);

    // Reset while receiving B.
    s = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01};
    send_bytes(s);
    check("getb_partial_a", data_a, 16'h1234);
    @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk);
    #1 check_reset("rst_getb");
    i_reset = 1'b0;
    s = '{8'hA5, 8'h22, 8'h05, 8'h00, 8'h03, 8'h00};
    frame(s);
    wait_idle("after_rst_getb");

    // Reset while waiting for a transmit done.
    s = '{8'hA5, 8'h20, 8'hFF, 8'h00, 8'h01, 8'h00};
    frame(s);
    wait_tx_start("rst_txwait");
    @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk);
    #1 check_reset("rst_txwait");
    while (exp_q.size() > rd_idx) void'(exp_q.pop_back());
    i_reset = 1'b0;
    repeat (12) @(posedge clk);
    base = tx_log.size();
    s = '{8'hA5, 8'h22, 8'h00, 8'h01, 8'h01, 8'h00};
    frame(s);
    wait_idle("after_rst_txwait");
    check("after_rst_byte0", tx_log[base], 8'hFF);
    check("after_rst_byte1", tx_log[base+1], 8'h00);

    check("final_all_bytes_sent", rd_idx, exp_q.size());
    checks += cmp_checks;
    errors += cmp_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
